// File: rtl/tcm_banked_mp_if.sv
// tcm_banked_mp_if: request/response bundle between the requesters and the
// banked TCM. Per-port fields are packed, port p at slice p.
`timescale 1ns/1ps
interface tcm_banked_mp_if #(
  parameter int DATA_WIDTH = 32,
  parameter int N_ENTRIES  = 4096,
  parameter int N_PORTS    = 3
);
  localparam int AW = $clog2(N_ENTRIES);
  localparam int BE = DATA_WIDTH / 8;

  logic [N_PORTS-1:0]            req_i;
  logic [N_PORTS-1:0]            we_i;
  logic [N_PORTS*BE-1:0]         be_i;
  logic [N_PORTS*AW-1:0]         addr_i;
  logic [N_PORTS*DATA_WIDTH-1:0] data_i;
  logic [N_PORTS-1:0]            gnt_o;
  logic [N_PORTS-1:0]            ready_o;
  logic [N_PORTS*DATA_WIDTH-1:0] data_o;

  modport master (
    output req_i, we_i, be_i, addr_i, data_i,
    input  gnt_o, ready_o, data_o
  );

  modport slave (
    input  req_i, we_i, be_i, addr_i, data_i,
    output gnt_o, ready_o, data_o
  );
endinterface

// File: rtl/tcm_banked_mp.sv
// tcm_banked_mp: multi-port, word-interleaved multi-bank TCM scratchpad.
// Every bank has its own round-robin arbiter, so requests to different banks
// proceed in parallel while same-bank requests serialise. Accesses are
// read-first: a granted write also returns the word it overwrote.
// Optional feature macro: TCM_OUTREG_EN adds an output register stage after
// the RAM read register (latency 2 instead of 1).
`timescale 1ns/1ps
module tcm_banked_mp #(
  parameter int    DATA_WIDTH = 32,
  parameter int    N_ENTRIES  = 4096,
  parameter int    N_PORTS    = 3,
  parameter int    N_BANKS    = 4,
  parameter string INIT_FILE  = ""
) (
  input  logic           clk_i,
  input  logic           rst_i,
  tcm_banked_mp_if.slave bus,
  output logic [31:0]    conflict_cnt_o
);
  localparam int AW  = $clog2(N_ENTRIES);
  localparam int BE  = DATA_WIDTH / 8;
  localparam int BW  = (N_BANKS > 1) ? $clog2(N_BANKS) : 0;
  localparam int BKW = (BW > 0) ? BW : 1;
  localparam int PW  = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

  function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [3:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {29'd0, b};
    return s[32] ? 32'hFFFF_FFFF : s[31:0];
  endfunction

  // Word-interleaved storage: address = row * N_BANKS + bank, so bank b owns
  // every address whose low bits equal b.
  logic [DATA_WIDTH-1:0] r_mem [N_ENTRIES];

  logic [AW-1:0]  w_addr [N_PORTS];
  logic [BKW-1:0] w_bank [N_PORTS];
  logic [PW-1:0]  r_ptr  [N_BANKS];
  logic           w_bgnt [N_BANKS];
  logic [PW-1:0]  w_bsel [N_BANKS];
  logic [N_PORTS-1:0] w_gnt;
  logic [3:0]     w_deny;
  logic [31:0]    r_conflict_cnt;

  logic [N_PORTS-1:0]            r_vld_p0;
  logic [N_PORTS*DATA_WIDTH-1:0] r_rdata_p0;

  // Split each port's address into its bank index.
  always_comb begin
    for (int p = 0; p < N_PORTS; p++) begin
      w_addr[p] = bus.addr_i[p*AW +: AW];
      w_bank[p] = BKW'(w_addr[p] & AW'(N_BANKS - 1));
    end
  end

  // Per-bank round-robin pick: first requester at or after the bank pointer.
  always_comb begin
    int idx;
    idx   = 0;
    w_gnt = '0;
    for (int b = 0; b < N_BANKS; b++) begin
      w_bgnt[b] = 1'b0;
      w_bsel[b] = '0;
      for (int k = 0; k < N_PORTS; k++) begin
        idx = int'(r_ptr[b]) + k;
        if (idx >= N_PORTS) idx = idx - N_PORTS;
        if (!w_bgnt[b] && !rst_i && bus.req_i[idx] && int'(w_bank[idx]) == b) begin
          w_bgnt[b] = 1'b1;
          w_bsel[b] = PW'(idx);
        end
      end
      if (w_bgnt[b]) w_gnt[w_bsel[b]] = 1'b1;
    end
  end

  assign bus.gnt_o = w_gnt;

  // Advance a bank's pointer past the port it just granted.
  always_ff @(posedge clk_i) begin
    for (int b = 0; b < N_BANKS; b++) begin
      if (rst_i) r_ptr[b] <= '0;
      else if (w_bgnt[b])
        r_ptr[b] <= (int'(w_bsel[b]) == N_PORTS - 1) ? '0 : w_bsel[b] + 1'b1;
    end
  end

  // Byte-masked write by each bank's granted port.
  always_ff @(posedge clk_i) begin
    for (int b = 0; b < N_BANKS; b++) begin
      if (w_bgnt[b] && bus.we_i[w_bsel[b]]) begin
        for (int i = 0; i < BE; i++) begin
          if (bus.be_i[int'(w_bsel[b])*BE + i])
            r_mem[w_addr[w_bsel[b]]][i*8 +: 8] <= bus.data_i[int'(w_bsel[b])*DATA_WIDTH + i*8 +: 8];
        end
      end
    end
  end

  // ---- stage p0: RAM read register (old word, read-first) ----
  // Valid flags for the read register; reset squashes in-flight accesses.
  always_ff @(posedge clk_i) begin
    if (rst_i) r_vld_p0 <= '0;
    else       r_vld_p0 <= w_gnt;
  end

  // Capture the pre-write word for each granted port; hold otherwise.
  always_ff @(posedge clk_i) begin
    for (int p = 0; p < N_PORTS; p++) begin
      if (rst_i)         r_rdata_p0[p*DATA_WIDTH +: DATA_WIDTH] <= '0;
      else if (w_gnt[p]) r_rdata_p0[p*DATA_WIDTH +: DATA_WIDTH] <= r_mem[w_addr[p]];
    end
  end

`ifdef TCM_OUTREG_EN
  // ---- stage p1: output register ----
  logic [N_PORTS-1:0]            r_vld_p1;
  logic [N_PORTS*DATA_WIDTH-1:0] r_rdata_p1;

  // Output register stage; data only moves when a valid word arrives.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_vld_p1   <= '0;
      r_rdata_p1 <= '0;
    end else begin
      r_vld_p1 <= r_vld_p0;
      for (int p = 0; p < N_PORTS; p++)
        if (r_vld_p0[p]) r_rdata_p1[p*DATA_WIDTH +: DATA_WIDTH] <= r_rdata_p0[p*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Reset masks ready immediately so nothing in flight is reported.
  assign bus.ready_o = r_vld_p1 & ~{N_PORTS{rst_i}};
  assign bus.data_o  = r_rdata_p1;
`else
  // Reset masks ready immediately so nothing in flight is reported.
  assign bus.ready_o = r_vld_p0 & ~{N_PORTS{rst_i}};
  assign bus.data_o  = r_rdata_p0;
`endif

  // Number of ports left waiting this cycle.
  always_comb begin
    w_deny = '0;
    for (int p = 0; p < N_PORTS; p++)
      if (bus.req_i[p] && !w_gnt[p]) w_deny = w_deny + 4'd1;
  end

  // Saturating conflict counter.
  always_ff @(posedge clk_i) begin
    if (rst_i) r_conflict_cnt <= '0;
    else       r_conflict_cnt <= sat_add32(r_conflict_cnt, w_deny);
  end

  assign conflict_cnt_o = r_conflict_cnt;
endmodule

// File: tb/tb_tcm_banked_mp.sv
// tb_tcm_banked_mp: scoreboard bench for tcm_banked_mp. The driver computes
// expected grants, counter and read data from a flat word-array model and
// pushes expected responses; an independent monitor pops and compares them.
`timescale 1ns/1ps
module tb_tcm_banked_mp;
  localparam int DW = 32;
  localparam int NE = 4096;
  localparam int NP = 3;
  localparam int NB = 4;
  localparam int AW = 12;
  localparam int BE = 4;
`ifdef TCM_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] cnt;

  tcm_banked_mp_if #(.DATA_WIDTH(DW), .N_ENTRIES(NE), .N_PORTS(NP)) bus ();

  tcm_banked_mp #(
    .DATA_WIDTH(DW), .N_ENTRIES(NE), .N_PORTS(NP), .N_BANKS(NB), .INIT_FILE("")
  ) dut (
    .clk_i(clk), .rst_i(rst), .bus(bus), .conflict_cnt_o(cnt)
  );

  always #5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    int          port;
    logic [31:0] data;
    bit          known;
    longint      due;
  } exp_t;
  exp_t q[$];

  logic [31:0] m_mem   [NE];
  bit          m_known [NE];
  int          m_ptr   [NB];
  logic [31:0] m_cnt = '0;

  logic [NP-1:0] s_req, s_we, g_exp, g_dut;
  logic [BE-1:0] s_be   [NP];
  logic [AW-1:0] s_addr [NP];
  logic [DW-1:0] s_dat  [NP];
  bit            hold   [NP];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic set_port(input int p, input bit rq, input bit w, input logic [3:0] be,
                          input logic [11:0] a, input logic [31:0] d);
    s_req[p] = rq; s_we[p] = w; s_be[p] = be; s_addr[p] = a; s_dat[p] = d;
  endtask

  task automatic clear_ports();
    for (int p = 0; p < NP; p++) set_port(p, 1'b0, 1'b0, 4'h0, 12'h0, 32'h0);
  endtask

  task automatic drive();
    bus.req_i = s_req;
    bus.we_i  = s_we;
    for (int p = 0; p < NP; p++) begin
      bus.be_i[p*BE +: BE]   = s_be[p];
      bus.addr_i[p*AW +: AW] = s_addr[p];
      bus.data_i[p*DW +: DW] = s_dat[p];
    end
  endtask

  // Expected grants: per bank, the first requesting port at or after the pointer.
  task automatic model_grant();
    g_exp = '0;
    if (!rst) begin
      for (int b = 0; b < NB; b++) begin
        for (int k = 0; k < NP; k++) begin
          int p;
          p = (m_ptr[b] + k) % NP;
          if (s_req[p] && (int'(s_addr[p]) % NB) == b) begin
            g_exp[p] = 1'b1;
            break;
          end
        end
      end
    end
  endtask

  task automatic model_commit();
    if (rst) begin
      m_cnt = '0;
      for (int b = 0; b < NB; b++) m_ptr[b] = 0;
    end else begin
      longint s;
      for (int p = 0; p < NP; p++) begin
        if (g_exp[p]) begin
          int   a;
          exp_t e;
          a       = int'(s_addr[p]);
          e.port  = p;
          e.data  = m_mem[a];
          e.known = m_known[a];
          e.due   = cyc + LAT;
          q.push_back(e);
          if (s_we[p]) begin
            for (int i = 0; i < BE; i++)
              if (s_be[p][i]) m_mem[a][i*8 +: 8] = s_dat[p][i*8 +: 8];
            m_known[a] = m_known[a] || (s_be[p] == 4'hF);
          end
          m_ptr[a % NB] = (p + 1) % NP;
        end
      end
      s = longint'(m_cnt) + longint'($countones(s_req & ~g_exp));
      m_cnt = (s > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : s[31:0];
    end
  endtask

  // One clock of stimulus: drive, check combinational grant, advance model.
  task automatic step();
    @(negedge clk);
    drive();
    #1;
    model_grant();
    g_dut = bus.gnt_o;
    check("gnt", g_dut, g_exp);
    model_commit();
    @(posedge clk);
    #2;
    check("conflict_cnt", cnt, m_cnt);
  endtask

  // Monitor: whatever the DUT reports as ready must match the scoreboard.
  initial begin : monitor
    logic [NP-1:0]    er, ek;
    logic [NP*DW-1:0] ed;
    exp_t             e;
    forever begin
      @(posedge clk);
      #1;
      er = '0; ek = '0; ed = '0;
      while (q.size() > 0 && q[0].due <= cyc) begin
        e = q.pop_front();
        er[e.port] = 1'b1;
        ek[e.port] = e.known;
        ed[e.port*DW +: DW] = e.data;
      end
      check("ready", bus.ready_o, er);
      for (int p = 0; p < NP; p++)
        if (er[p] && ek[p] && bus.ready_o[p])
          check($sformatf("data_p%0d", p), bus.data_o[p*DW +: DW], ed[p*DW +: DW]);
    end
  end

  initial begin : driver
    for (int b = 0; b < NB; b++) m_ptr[b] = 0;
    for (int p = 0; p < NP; p++) hold[p] = 1'b0;
    clear_ports();
    drive();

    // Reset held two cycles with every port requesting a write.
    rst = 1'b1;
    for (int p = 0; p < NP; p++) set_port(p, 1'b1, 1'b1, 4'hF, 12'(p * 5), 32'hFFFF_0000 + p);
    step();
    step();
    check("rst_data", bus.data_o, '0);
    check("rst_cnt", cnt, 32'd0);
    rst = 1'b0;

    // Two ports on bank 0 held for four cycles: strict alternation.
    clear_ports();
    set_port(0, 1'b1, 1'b0, 4'h0, 12'h004, 32'h0);
    set_port(1, 1'b1, 1'b0, 4'h0, 12'h008, 32'h0);
    for (int k = 0; k < 4; k++) begin
      step();
      check($sformatf("arb_alt%0d", k), g_dut, (k % 2 == 0) ? 3'b001 : 3'b010);
    end
    check("arb_cnt", cnt, 32'd4);

    // Three different banks in one cycle: all granted, no conflict.
    clear_ports();
    set_port(0, 1'b1, 1'b0, 4'h0, 12'h001, 32'h0);
    set_port(1, 1'b1, 1'b0, 4'h0, 12'h002, 32'h0);
    set_port(2, 1'b1, 1'b0, 4'h0, 12'h003, 32'h0);
    step();
    check("par_gnt", g_dut, 3'b111);
    check("par_cnt", cnt, 32'd4);

    // Full write, partial byte write, read back.
    clear_ports();
    set_port(0, 1'b1, 1'b1, 4'hF, 12'h010, 32'hDEAD_BEEF);
    step();
    set_port(0, 1'b1, 1'b1, 4'b0010, 12'h010, 32'h0000_AA00);
    step();
    set_port(0, 1'b1, 1'b0, 4'h0, 12'h010, 32'h0);
    step();
    clear_ports();
    repeat (LAT - 1) step();
    check("be_merge_rdy", bus.ready_o[0], 1'b1);
    check("be_merge", bus.data_o[31:0], 32'hDEAD_AAEF);

    // Same-word write (P1) and read (P2) in one cycle serialise.
    clear_ports();
    set_port(0, 1'b1, 1'b1, 4'hF, 12'h020, 32'h0);
    step();
    clear_ports();
    set_port(1, 1'b1, 1'b1, 4'hF, 12'h020, 32'h1234_5678);
    set_port(2, 1'b1, 1'b0, 4'h0, 12'h020, 32'h0);
    step();
    check("raw_first", g_dut, 3'b010);
    set_port(1, 1'b0, 1'b0, 4'h0, 12'h0, 32'h0);
    step();
    check("raw_second", g_dut, 3'b100);
    clear_ports();
    repeat (LAT - 1) step();
    check("raw_read", bus.data_o[2*DW +: DW], 32'h1234_5678);

    // Read granted, then reset raised right after the grant edge.
    clear_ports();
    step();
    set_port(0, 1'b1, 1'b0, 4'h0, 12'h010, 32'h0);
    @(negedge clk);
    drive();
    #1;
    check("sq_gnt", bus.gnt_o, 3'b001);
    @(posedge clk);
    #0.5;
    rst = 1'b1;
    q.delete();
    clear_ports();
    step();
    rst = 1'b0;
    step();
    step();
    check("sq_no_ready", bus.ready_o, 3'b000);

    // Counter saturation from a preloaded value.
    @(negedge clk);
    force dut.r_conflict_cnt = 32'hFFFF_FFFE;
    #1;
    release dut.r_conflict_cnt;
    m_cnt = 32'hFFFF_FFFE;
    check("preload", cnt, 32'hFFFF_FFFE);
    set_port(0, 1'b1, 1'b0, 4'h0, 12'h000, 32'h0);
    set_port(1, 1'b1, 1'b0, 4'h0, 12'h004, 32'h0);
    set_port(2, 1'b1, 1'b0, 4'h0, 12'h008, 32'h0);
    step();
    check("sat1", cnt, 32'hFFFF_FFFF);
    set_port(0, 1'b0, 1'b0, 4'h0, 12'h000, 32'h0);
    step();
    check("sat2", cnt, 32'hFFFF_FFFF);

    // Randomised traffic over a small address window to force conflicts.
    clear_ports();
    for (int it = 0; it < 400; it++) begin
      for (int p = 0; p < NP; p++) begin
        if (hold[p]) begin
          if ($urandom_range(0, 7) == 0) s_req[p] = 1'b0;
        end else begin
          s_req[p]  = ($urandom_range(0, 3) != 0);
          s_we[p]   = 1'($urandom_range(0, 1));
          s_be[p]   = ($urandom_range(0, 1) != 0) ? 4'hF : 4'($urandom);
          s_addr[p] = 12'($urandom_range(0, 47));
          s_dat[p]  = $urandom;
        end
      end
      step();
      for (int p = 0; p < NP; p++) hold[p] = s_req[p] && !g_exp[p];
    end

    clear_ports();
    repeat (LAT + 1) step();
    check("drain", q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
